// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use/RAW stalls, branch flush, multi-cycle EX sequencing.
// Optional macro FORWARDING_EN enables EX operand forwarding; without it RAW hazards stall instead.
module pipeline_hazard_ctrl #(
    parameter int AWL       = 6,
    parameter int MC_CYCLES = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [AWL-2:0] RsD,
    input  logic [AWL-2:0] RtD,
    input  logic [AWL-2:0] RsE,
    input  logic [AWL-2:0] RtE,
    input  logic [AWL-2:0] WriteRegE,
    input  logic [AWL-2:0] WriteRegM,
    input  logic [AWL-2:0] WriteRegW,
    input  logic           RegWriteE,
    input  logic           RegWriteM,
    input  logic           RegWriteW,
    input  logic           MemtoRegE,
    input  logic           BranchTakenD,
    input  logic           MultiStartE,
    output logic           StallF,
    output logic           StallD,
    output logic           StallE,
    output logic           FlushD,
    output logic           FlushE,
    output logic           FlushM,
    output logic [1:0]     ForwardAE,
    output logic [1:0]     ForwardBE,
    output logic           MCBusy
);

    localparam int RW = AWL - 1;
    localparam int CW = $clog2(MC_CYCLES);

    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_MC_WAIT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mc_stall;
    logic          hz_stall;

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src,
                                           input logic          wr_m,
                                           input logic [RW-1:0] dst_m,
                                           input logic          wr_w,
                                           input logic [RW-1:0] dst_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (wr_m && (dst_m == src))
                sel = 2'b10;
            else if (wr_w && (dst_w == src))
                sel = 2'b01;
        end
        return sel;
    endfunction
`else
    // Writeback is written in the first half-cycle, so only EX and MEM producers stall a reader.
    function automatic logic raw_dep(input logic [RW-1:0] src,
                                     input logic          wr_e,
                                     input logic [RW-1:0] dst_e,
                                     input logic          wr_m,
                                     input logic [RW-1:0] dst_m);
        return (src != '0) && ((wr_e && (dst_e == src)) || (wr_m && (dst_m == src)));
    endfunction

    logic unused_nofwd;
    assign unused_nofwd = ^{RsE, RtE, WriteRegW, RegWriteW, MemtoRegE};
`endif

    always_comb begin
`ifdef FORWARDING_EN
        hz_stall = MemtoRegE && RegWriteE && (WriteRegE != '0) &&
                   ((WriteRegE == RsD) || (WriteRegE == RtD));
`else
        hz_stall = raw_dep(RsD, RegWriteE, WriteRegE, RegWriteM, WriteRegM) ||
                   raw_dep(RtD, RegWriteE, WriteRegE, RegWriteM, WriteRegM);
`endif
        mc_stall = ((state_q == S_RUN) && MultiStartE) ||
                   ((state_q == S_MC_WAIT) && (cnt_q != '0));
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RST) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            // The multi-cycle hold outranks hazard stalls; a stalled branch waits to be re-evaluated.
            if (mc_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (hz_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
            FlushD = BranchTakenD && !(StallF || StallD || StallE);
`ifdef FORWARDING_EN
            ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
            ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (MultiStartE) begin
                    state_d = S_MC_WAIT;
                    cnt_d   = CW'(MC_CYCLES - 2);
                end
            end
            default: begin
                if (cnt_q != '0)
                    cnt_d = cnt_q - CW'(1);
                else
                    state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign MCBusy = (state_q == S_MC_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random stimulus vs. a cycle-position model.
module tb_pipeline_hazard_ctrl;

    localparam int AWL = 6;
    localparam int MC  = 4;
    localparam int RW  = AWL - 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic [RW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenD, MultiStartE;
    logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MCBusy;
    logic [1:0]    ForwardAE, ForwardBE;

    pipeline_hazard_ctrl #(.AWL(AWL), .MC_CYCLES(MC)) dut (
        .CLK(CLK), .RST(RST),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .BranchTakenD(BranchTakenD), .MultiStartE(MultiStartE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MCBusy(MCBusy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: position of the multi-cycle op within its EX residency (-1 = none in flight).
    int mc_pos = -1;
    int mc_pos_next;

    logic e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_busy;
    logic [1:0] e_fa, e_fb;
    logic s_sf, s_fd, s_busy, s_fm;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [RW-1:0] r);
`ifdef FORWARDING_EN
        if (r == 0) return 2'b00;
        if (RegWriteM && WriteRegM == r) return 2'b10;
        if (RegWriteW && WriteRegW == r) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic bit ref_depends(input logic [RW-1:0] r);
        if (r == 0) return 1'b0;
`ifdef FORWARDING_EN
        return MemtoRegE && RegWriteE && WriteRegE == r;
`else
        return (RegWriteE && WriteRegE == r) || (RegWriteM && WriteRegM == r);
`endif
    endfunction

    task automatic evaluate();
        int  pos_now;
        bit  mc, hz;
        e_busy = (mc_pos >= 1);
        pos_now = (mc_pos >= 0) ? mc_pos : (MultiStartE ? 0 : -1);
        mc = (pos_now >= 0) && (pos_now < MC - 1);
        hz = ref_depends(RsD) || ref_depends(RtD);
        if (RST) begin
            {e_sf, e_sd, e_se} = 3'b000;
            {e_fd, e_fe, e_fm} = 3'b111;
            e_fa = 2'b00; e_fb = 2'b00;
            mc_pos_next = -1;
        end else begin
            e_se = mc;
            e_fm = mc;
            e_sf = mc || hz;
            e_sd = mc || hz;
            e_fe = !mc && hz;
            e_fd = BranchTakenD && !(mc || hz);
            e_fa = ref_fwd(RsE);
            e_fb = ref_fwd(RtE);
            mc_pos_next = (pos_now >= 0 && pos_now + 1 < MC) ? pos_now + 1 : -1;
        end
    endtask

    // Inputs are driven just after a falling edge; outputs are checked before the next rising edge.
    task automatic cycle();
        #2;
        evaluate();
        chk("StallF", StallF, e_sf);
        chk("StallD", StallD, e_sd);
        chk("StallE", StallE, e_se);
        chk("FlushD", FlushD, e_fd);
        chk("FlushE", FlushE, e_fe);
        chk("FlushM", FlushM, e_fm);
        chk("ForwardAE", ForwardAE, e_fa);
        chk("ForwardBE", ForwardBE, e_fb);
        chk("MCBusy", MCBusy, e_busy);
        s_sf = StallF; s_fd = FlushD; s_busy = MCBusy; s_fm = FlushM;
        @(posedge CLK);
        mc_pos = mc_pos_next;
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        RST = 1'b0;
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; BranchTakenD = 1'b0; MultiStartE = 1'b0;
    endtask

    task automatic rand_inputs();
        RST = ($urandom % 40 == 0);
        RsD = RW'($urandom_range(0, 3)); RtD = RW'($urandom_range(0, 3));
        RsE = RW'($urandom_range(0, 3)); RtE = RW'($urandom_range(0, 3));
        WriteRegE = RW'($urandom_range(0, 3));
        WriteRegM = RW'($urandom_range(0, 3));
        WriteRegW = RW'($urandom_range(0, 3));
        RegWriteE = $urandom % 2; RegWriteM = $urandom % 2; RegWriteW = $urandom % 2;
        MemtoRegE = $urandom % 2; BranchTakenD = $urandom % 2;
        MultiStartE = ($urandom % 6 == 0) || (mc_pos >= 0 && $urandom % 4 != 0);
    endtask

    logic [4:0] sf_pat, busy_pat, fm_pat;
    int         stall_cnt;

    initial begin
        clear_inputs();
        @(negedge CLK);

        // Reset held two cycles, then released.
        RST = 1'b1;
        cycle();
        cycle();
        chk("rst_flushD", s_fd, 1'b1);
        RST = 1'b0;
        cycle();
        chk("rel_busy", s_busy, 1'b0);

        // Load-use, then the load sits in MEM.
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5; RsD = 5;
        cycle();
        chk("lu_stallF", s_sf, 1'b1);
        clear_inputs();
        RegWriteM = 1'b1; WriteRegM = 5; RsE = 5;
        cycle();

        // Forwarding selects: MEM over WB, WB alone, reg 0.
        clear_inputs();
        RegWriteM = 1'b1; WriteRegM = 3; RegWriteW = 1'b1; WriteRegW = 3; RsE = 3; RtE = 3;
        cycle();
        RegWriteM = 1'b0;
        cycle();
        RegWriteM = 1'b1; WriteRegM = 0; RsE = 0; RtE = 0;
        cycle();

        // Multi-cycle op held for MC cycles, then one more idle cycle.
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            MultiStartE = (i < MC);
            cycle();
            sf_pat[i] = s_sf; busy_pat[i] = s_busy; fm_pat[i] = s_fm;
        end
        chk("mc_stall_pat", sf_pat, 5'b00111);
        chk("mc_flushM_pat", fm_pat, 5'b00111);
        chk("mc_busy_pat", busy_pat, 5'b01110);

        // Taken branch under a load-use stall, then with the hazard gone.
        clear_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 9; RtD = 9; BranchTakenD = 1'b1;
        cycle();
        chk("br_stalled", s_fd, 1'b0);
        MemtoRegE = 1'b0; RegWriteE = 1'b0; WriteRegE = 0;
        cycle();
        chk("br_flush", s_fd, 1'b1);

        // Reset during the second MC_WAIT cycle aborts the op.
        clear_inputs();
        MultiStartE = 1'b1;
        cycle();
        cycle();
        RST = 1'b1;
        cycle();
        RST = 1'b0; MultiStartE = 1'b0;
        cycle();
        chk("abort_busy", s_busy, 1'b0);
        chk("abort_stall", s_sf, 1'b0);

`ifndef FORWARDING_EN
        // Non-load producer: stalls while in EX and again in MEM.
        clear_inputs();
        stall_cnt = 0;
        RegWriteE = 1'b1; WriteRegE = 7; RsD = 7;
        cycle();
        stall_cnt += int'(s_sf);
        RegWriteE = 1'b0; WriteRegE = 0; RegWriteM = 1'b1; WriteRegM = 7;
        cycle();
        stall_cnt += int'(s_sf);
        RegWriteM = 1'b0; WriteRegM = 0; RegWriteW = 1'b1; WriteRegW = 7;
        cycle();
        stall_cnt += int'(s_sf);
        chk("raw_stall_cycles", stall_cnt, 2);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
